onehot_digit_sequencer: RTL and testbench

- Upstream stage for the one-hot-to-segment OR-encoder on the TinyTapeout tile.
- Converts two raw pushbuttons, plus an optional auto-advance timer, into an 8-bit one-hot digit code.
- Bit k of the code selects digit k; the encoder consumes the code directly on ui_in-equivalent wiring.
- Handles synchronisation, debounce, edge detection, wrap-around index counting and a blanking override.

---
 rtl/onehot_digit_sequencer.sv | 118 +++++++++++
 tb/tb_onehot_digit_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_digit_sequencer.sv
`default_nettype none
// ============================================================================
// onehot_digit_sequencer : debounced up/down buttons plus auto-advance timer
//                          driving a wrap-around 3-bit index and its one-hot code
// Revision 1.0
// ============================================================================
module onehot_digit_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_PERIOD     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       auto_en,
  input  logic       blank,
  output logic [7:0] digit_onehot,
  output logic [2:0] digit_idx,
  output logic       step_pulse
);

  localparam int c_db_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_tm_w = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_tm_w-1:0] c_tm_last = c_tm_w'(AUTO_PERIOD - 1);

  // Button lanes: bit 0 = up, bit 1 = down.
  logic [1:0] btn_raw;
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] level_q, level_d;
  logic [1:0] level_prev_q, level_prev_d;
  logic [1:0][c_db_w-1:0] cnt_q, cnt_d;
  logic [1:0] press;

  logic [c_tm_w-1:0] timer_q, timer_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        onehot_q, onehot_d;
  logic              step_q, step_d;

  assign btn_raw = {btn_down, btn_up};

  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    level_prev_d = level_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] == level_q[b]) begin
        cnt_d[b] = '0;
      end else if (cnt_q[b] == c_db_last) begin
        level_d[b] = sync2_q[b];
        cnt_d[b]   = '0;
      end else begin
        cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
  end

  // Only the rising edge of the accepted level counts; release is ignored.
  assign press = level_q & ~level_prev_q;

  always_comb begin
    idx_d   = idx_q;
    timer_d = timer_q;
    if (press[0] && press[1]) begin
      timer_d = '0;
    end else if (press[0]) begin
      idx_d   = idx_q + 3'd1;
      timer_d = '0;
    end else if (press[1]) begin
      idx_d   = idx_q - 3'd1;
      timer_d = '0;
    end else if (auto_en) begin
      if (timer_q == c_tm_last) begin
        idx_d   = idx_q + 3'd1;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
    end
    step_d   = (idx_d != idx_q);
    onehot_d = blank ? 8'h00 : (8'h01 << idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      cnt_q        <= '0;
      timer_q      <= '0;
      idx_q        <= 3'd0;
      onehot_q     <= 8'h01;
      step_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      onehot_q     <= onehot_d;
      step_q       <= step_d;
    end
  end

  assign digit_onehot = onehot_q;
  assign digit_idx    = idx_q;
  assign step_pulse   = step_q;

endmodule
`default_nettype wire

// File: tb/tb_onehot_digit_sequencer.sv
`default_nettype none
// ============================================================================
// tb_onehot_digit_sequencer : directed vector table plus randomized run
//                             against a cycle-level reference model
// Revision 1.0
// ============================================================================
module tb_onehot_digit_sequencer;

  localparam int DEB = 4;
  localparam int PER = 16;

  logic       clk = 1'b0;
  logic       rst, btn_up, btn_down, auto_en, blank;
  logic [7:0] digit_onehot;
  logic [2:0] digit_idx;
  logic       step_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;
  int cyc = 0;

  onehot_digit_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_PERIOD    (PER)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .auto_en     (auto_en),
    .blank       (blank),
    .digit_onehot(digit_onehot),
    .digit_idx   (digit_idx),
    .step_pulse  (step_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples age through a two-deep history, a run length
  // of disagreeing samples decides when the accepted level flips.
  int       m_h1[2], m_h2[2], m_lvl[2], m_prev[2], m_run[2];
  int       m_idx, m_timer, m_step;
  logic [7:0] m_oh;

  task automatic model_step();
    int raw[2];
    bit ev[2];
    int nidx;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_h1[b] = 0; m_h2[b] = 0; m_lvl[b] = 0; m_prev[b] = 0; m_run[b] = 0;
      end
      m_idx = 0; m_timer = 0; m_oh = 8'h01; m_step = 0;
    end else begin
      raw[0] = int'(btn_up);
      raw[1] = int'(btn_down);
      for (int b = 0; b < 2; b++) begin
        ev[b] = (m_lvl[b] == 1) && (m_prev[b] == 0);
        m_prev[b] = m_lvl[b];
        if (m_h2[b] == m_lvl[b]) m_run[b] = 0;
        else if (m_run[b] + 1 == DEB) begin m_lvl[b] = m_h2[b]; m_run[b] = 0; end
        else m_run[b] = m_run[b] + 1;
        m_h2[b] = m_h1[b];
        m_h1[b] = raw[b];
      end
      nidx = m_idx;
      if (ev[0] && ev[1]) m_timer = 0;
      else if (ev[0]) begin nidx = (m_idx + 1) % 8; m_timer = 0; end
      else if (ev[1]) begin nidx = (m_idx + 7) % 8; m_timer = 0; end
      else if (auto_en) begin
        if (m_timer == PER - 1) begin nidx = (m_idx + 1) % 8; m_timer = 0; end
        else m_timer = m_timer + 1;
      end else m_timer = 0;
      m_step = (nidx != m_idx) ? 1 : 0;
      m_idx  = nidx;
      m_oh   = blank ? 8'h00 : 8'(1 << nidx);
    end
  endtask

  task automatic check(input string name, input int k, input logic [15:0] act,
                       input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    if (chk_on)
      check("model", cyc, {4'd0, digit_idx, digit_onehot, step_pulse},
            {4'd0, m_idx[2:0], m_oh, m_step[0]});
  endtask

  typedef struct {
    bit         rst, up, dn, au, bl;
    int         cycles;
    int         idx;
    logic [7:0] oh;
    int         pulses;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit u, bit d, bit a, bit b, int n,
                              int idx, logic [7:0] oh, int p);
    vec_t v;
    v.rst = r; v.up = u; v.dn = d; v.au = a; v.bl = b; v.cycles = n;
    v.idx = idx; v.oh = oh; v.pulses = p;
    tbl.push_back(v);
  endfunction

  task automatic run_rec(input vec_t v, input int k);
    int pulses;
    pulses   = 0;
    rst      = v.rst;
    btn_up   = v.up;
    btn_down = v.dn;
    auto_en  = v.au;
    blank    = v.bl;
    for (int i = 0; i < v.cycles; i++) begin
      tick();
      if (step_pulse) pulses++;
    end
    check("vec_idx", k, 16'(digit_idx), 16'(v.idx));
    check("vec_onehot", k, 16'(digit_onehot), 16'(v.oh));
    check("vec_pulses", k, 16'(pulses), 16'(v.pulses));
  endtask

  initial begin
    //   rst up dn au bl  n   idx  onehot pulses
    add(0, 0, 0, 0, 0, 50, 0, 8'h01, 0);
    add(0, 1, 0, 0, 0, 20, 1, 8'h02, 1);
    add(0, 0, 0, 0, 0, 20, 1, 8'h02, 0);
    for (int g = 0; g < 5; g++) begin
      add(0, 1, 0, 0, 0, 3, 1, 8'h02, 0);
      add(0, 0, 0, 0, 0, 5, 1, 8'h02, 0);
    end
    for (int k = 2; k <= 8; k++) begin
      add(0, 1, 0, 0, 0, 10, k % 8, 8'(1 << (k % 8)), 1);
      add(0, 0, 0, 0, 0, 10, k % 8, 8'(1 << (k % 8)), 0);
    end
    add(0, 0, 1, 0, 0, 10, 7, 8'h80, 1);
    add(0, 0, 0, 0, 0, 10, 7, 8'h80, 0);
    add(0, 1, 0, 0, 0, 10, 0, 8'h01, 1);
    add(0, 0, 0, 0, 0, 10, 0, 8'h01, 0);
    add(0, 1, 1, 0, 0, 10, 0, 8'h01, 0);
    add(0, 0, 0, 0, 0, 10, 0, 8'h01, 0);
    add(0, 0, 0, 1, 0, 16, 1, 8'h02, 1);
    add(0, 0, 0, 1, 0, 16, 2, 8'h04, 1);
    add(0, 0, 0, 1, 0, 16, 3, 8'h08, 1);
    add(0, 0, 0, 1, 1, 32, 5, 8'h00, 2);
    add(0, 0, 0, 1, 0, 1,  5, 8'h20, 0);
    add(0, 0, 0, 0, 0, 5,  5, 8'h20, 0);
    // Press lands on edge 15 of the auto window, one before expiry.
    add(0, 0, 0, 1, 0, 8,  5, 8'h20, 0);
    add(0, 1, 0, 1, 0, 7,  6, 8'h40, 1);
    add(0, 1, 0, 1, 0, 3,  6, 8'h40, 0);
    add(0, 0, 0, 1, 0, 12, 6, 8'h40, 0);
    add(0, 0, 0, 1, 0, 1,  7, 8'h80, 1);
    add(0, 0, 0, 0, 0, 20, 7, 8'h80, 0);
    add(0, 0, 0, 0, 1, 3,  7, 8'h00, 0);
    add(0, 0, 0, 0, 0, 1,  7, 8'h80, 0);
    add(0, 1, 0, 0, 0, 5,  7, 8'h80, 0);
    add(1, 0, 0, 0, 0, 2,  0, 8'h01, 0);
    add(0, 0, 0, 0, 0, 20, 0, 8'h01, 0);

    rst = 1'b1; btn_up = 1'b0; btn_down = 1'b0; auto_en = 1'b0; blank = 1'b0;
    tick();
    tick();
    check("reset_idx", 0, 16'(digit_idx), 16'd0);
    check("reset_onehot", 0, 16'(digit_onehot), 16'h0001);
    check("reset_step", 0, 16'(step_pulse), 16'd0);
    chk_on = 1;

    foreach (tbl[k]) run_rec(tbl[k], k);

    for (int seg = 0; seg < 400; seg++) begin
      int len;
      len      = $urandom_range(1, 14);
      rst      = ($urandom_range(0, 59) == 0);
      btn_up   = ($urandom_range(0, 2) == 0);
      btn_down = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) auto_en = ~auto_en;
      blank    = ($urandom_range(0, 4) == 0);
      if (rst) len = $urandom_range(1, 2);
      for (int i = 0; i < len; i++) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
